register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//   Architectural register file with rename tags. Sits between decoder and reorder buffer.
//   Decoder reads source operands here and receives either a value or a ROB dependency tag.
//   Decoder renames a destination register to a new ROB entry. ROB retires results via the commit port.
//   The block queries the ROB for results that have completed but are not yet committed.
// PARAMETERS
//   REG_COUNT  32  number of architectural registers; x0 hardwired to zero
//   REG_WIDTH   5  register index width, log2(REG_COUNT)
//   ROB_WIDTH   4  ROB id width; must equal the ROB's id width
// PORTS
//   clk_in             in   1          clock; all state updates on posedge
//   rst_in             in   1          asynchronous, active-low reset
//   rdy_in             in   1          global enable; low = hold all state
//   flush              in   1          mispredict flush, qualified by rdy_in
//   dec_rs1            in   REG_WIDTH  source register j index
//   dec_rs2            in   REG_WIDTH  source register k index
//   dec_val_j          out  32         operand j value, meaningful when dec_has_dep_j=0
//   dec_val_k          out  32         operand k value, meaningful when dec_has_dep_k=0
//   dec_has_dep_j      out  1          1 = operand j pending on ROB entry dec_dep_j
//   dec_has_dep_k      out  1          1 = operand k pending on ROB entry dec_dep_k
//   dec_dep_j          out  ROB_WIDTH  ROB tag for operand j
//   dec_dep_k          out  ROB_WIDTH  ROB tag for operand k
//   dec_rename_en      in   1          rename dec_rename_reg to dec_rename_rob_id this cycle
//   dec_rename_reg     in   REG_WIDTH  destination register being renamed
//   dec_rename_rob_id  in   ROB_WIDTH  ROB entry allocated to it
//   rob_id_j           out  ROB_WIDTH  tag of rs1, presented to ROB for lookup
//   rob_id_k           out  ROB_WIDTH  tag of rs2, presented to ROB for lookup
//   rob_ready_j        in   1          ROB: entry rob_id_j has its result
//   rob_ready_k        in   1          ROB: entry rob_id_k has its result
//   rob_data_j         in   32         ROB result for rob_id_j
//   rob_data_k         in   32         ROB result for rob_id_k
//   commit_reg_id      in   REG_WIDTH  committing destination; 0 = no register write
//   commit_data        in   32         committed value
//   commit_rob_id      in   ROB_WIDTH  ROB id of the committing entry
// BEHAVIOUR
//   State: val[REG_COUNT] (32b), busy[REG_COUNT], tag[REG_COUNT] (ROB_WIDTH).
//   Reset (rst_in low, async): val, busy and tag are all cleared.
//     Outputs after reset: dec_val=0, dec_has_dep=0, dec_dep=0, rob_id=0.
//   Operand read: combinational, zero latency. Per port (j shown; k identical):
//     rob_id_j = tag[dec_rs1], regardless of busy.
//     1. dec_rs1==0: value 0, no dependency.
//     2. busy && tag==commit_rob_id && commit_reg_id==dec_rs1: value commit_data, no dependency.
//        This is a commit bypass.
//     3. busy && rob_ready_j: value rob_data_j, no dependency.
//     4. busy otherwise: has_dep=1, dep=tag; dec_val_j=0.
//     5. not busy: value val[dec_rs1], no dependency.
//     When has_dep=0, dec_dep_j = 0.
//   Update on posedge, when rdy_in=1 and flush=0:
//     Commit (commit_reg_id!=0):
//       val[commit_reg_id] <= commit_data.
//       If busy && tag==commit_rob_id, busy is cleared.
//       A stale tag (the register was renamed again later) leaves busy and tag unchanged.
//     Rename (dec_rename_en && dec_rename_reg!=0): busy <= 1, tag <= dec_rename_rob_id.
//     Same register in the same cycle: rename wins for busy/tag; commit still writes val.
//     Operands read in the same cycle as a rename of that register see the pre-rename state.
//   Flush (rdy_in=1, flush=1):
//     All busy and tag bits are cleared; val is kept.
//     Commit and rename inputs are ignored that cycle; the ROB discards its head that cycle.
//   rdy_in=0: no state changes; combinational outputs remain valid.
//   x0: never written, never busy; commits and renames targeting 0 are dropped.
//   Reset mid-operation: asynchronous clear overrides any pending commit, rename or flush.
// TESTING
//   1. Reset, then read rs1=5, rs2=0 -> val 0/0, has_dep 0/0.
//   2. Rename x5->rob 3; read x5 with rob_ready_j=0 -> has_dep_j=1, dep_j=3.
//      Then set rob_ready_j=1, rob_data_j=0xAA -> val 0xAA, has_dep 0.
//   3. Commit x5=0x1234, rob 3, while reading x5 -> bypass gives 0x1234, no dependency.
//      Next cycle: busy[5]=0 and val[5]=0x1234.
//   4. Rename x7->rob 2, then x7->rob 6; commit x7 rob 2 with 0x55.
//      -> val[7]=0x55, busy[7] stays 1, tag=6.
//   5. Same-cycle commit x9 rob 1 and rename x9->rob 4.
//      -> val[9] updated, busy[9]=1, tag=4.
//   6. Busy x3/x4, then flush with rdy_in=1 and commit x3 asserted.
//      -> all busy=0, val[3] unchanged. Repeat with rdy_in=0 -> no change.

Source files
------------

// File: rtl/register_file.sv
// Architectural register file with ROB rename tags; zero-latency operand read, single-cycle update.
// No backpressure: rdy_in low freezes all state while the read path keeps answering.
module register_file #(
  parameter int REG_COUNT = 32,
  parameter int REG_WIDTH = 5,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush,
  input  logic [REG_WIDTH-1:0] dec_rs1,
  input  logic [REG_WIDTH-1:0] dec_rs2,
  output logic [31:0]          dec_val_j,
  output logic [31:0]          dec_val_k,
  output logic                 dec_has_dep_j,
  output logic                 dec_has_dep_k,
  output logic [ROB_WIDTH-1:0] dec_dep_j,
  output logic [ROB_WIDTH-1:0] dec_dep_k,
  input  logic                 dec_rename_en,
  input  logic [REG_WIDTH-1:0] dec_rename_reg,
  input  logic [ROB_WIDTH-1:0] dec_rename_rob_id,
  output logic [ROB_WIDTH-1:0] rob_id_j,
  output logic [ROB_WIDTH-1:0] rob_id_k,
  input  logic                 rob_ready_j,
  input  logic                 rob_ready_k,
  input  logic [31:0]          rob_data_j,
  input  logic [31:0]          rob_data_k,
  input  logic [REG_WIDTH-1:0] commit_reg_id,
  input  logic [31:0]          commit_data,
  input  logic [ROB_WIDTH-1:0] commit_rob_id
);

  typedef struct packed {
    logic                 has_dep;
    logic [ROB_WIDTH-1:0] dep;
    logic [31:0]          val;
  } rd_t;

  logic [31:0]          val_q  [REG_COUNT];
  logic [31:0]          val_d  [REG_COUNT];
  logic                 busy_q [REG_COUNT];
  logic                 busy_d [REG_COUNT];
  logic [ROB_WIDTH-1:0] tag_q  [REG_COUNT];
  logic [ROB_WIDTH-1:0] tag_d  [REG_COUNT];

  // Priority: x0, same-cycle commit bypass, ROB forward, pending tag, then architectural value.
  function automatic rd_t read_op(
    input logic [REG_WIDTH-1:0] rs,
    input logic                 busy,
    input logic [ROB_WIDTH-1:0] tag,
    input logic [31:0]          val,
    input logic                 ready,
    input logic [31:0]          data,
    input logic [REG_WIDTH-1:0] c_reg,
    input logic [ROB_WIDTH-1:0] c_rob,
    input logic [31:0]          c_data
  );
    rd_t r;
    r = '0;
    if (rs != '0) begin
      if (!busy) begin
        r.val = val;
      end else if (tag == c_rob && c_reg == rs) begin
        r.val = c_data;
      end else if (ready) begin
        r.val = data;
      end else begin
        r.has_dep = 1'b1;
        r.dep     = tag;
      end
    end
    return r;
  endfunction

  rd_t rd_j, rd_k;

  always_comb begin
    rd_j = read_op(dec_rs1, busy_q[dec_rs1], tag_q[dec_rs1], val_q[dec_rs1],
                   rob_ready_j, rob_data_j, commit_reg_id, commit_rob_id, commit_data);
    rd_k = read_op(dec_rs2, busy_q[dec_rs2], tag_q[dec_rs2], val_q[dec_rs2],
                   rob_ready_k, rob_data_k, commit_reg_id, commit_rob_id, commit_data);
  end

  assign dec_val_j     = rd_j.val;
  assign dec_has_dep_j = rd_j.has_dep;
  assign dec_dep_j     = rd_j.dep;
  assign dec_val_k     = rd_k.val;
  assign dec_has_dep_k = rd_k.has_dep;
  assign dec_dep_k     = rd_k.dep;
  assign rob_id_j      = tag_q[dec_rs1];
  assign rob_id_k      = tag_q[dec_rs2];

  // Commit is applied before rename so a same-register rename overrides busy/tag.
  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rdy_in) begin
      if (flush) begin
        for (int i = 0; i < REG_COUNT; i++) begin
          busy_d[i] = 1'b0;
          tag_d[i]  = '0;
        end
      end else begin
        if (commit_reg_id != '0) begin
          val_d[commit_reg_id] = commit_data;
          if (busy_q[commit_reg_id] && tag_q[commit_reg_id] == commit_rob_id)
            busy_d[commit_reg_id] = 1'b0;
        end
        if (dec_rename_en && dec_rename_reg != '0) begin
          busy_d[dec_rename_reg] = 1'b1;
          tag_d[dec_rename_reg]  = dec_rename_rob_id;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        val_q[i]  <= '0;
        busy_q[i] <= 1'b0;
        tag_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        val_q[i]  <= val_d[i];
        busy_q[i] <= busy_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Randomized and directed bench for register_file against an array-based reference model.
module tb_register_file;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush;
  logic [4:0]  dec_rs1, dec_rs2;
  logic [31:0] dec_val_j, dec_val_k;
  logic        dec_has_dep_j, dec_has_dep_k;
  logic [3:0]  dec_dep_j, dec_dep_k;
  logic        dec_rename_en;
  logic [4:0]  dec_rename_reg;
  logic [3:0]  dec_rename_rob_id;
  logic [3:0]  rob_id_j, rob_id_k;
  logic        rob_ready_j, rob_ready_k;
  logic [31:0] rob_data_j, rob_data_k;
  logic [4:0]  commit_reg_id;
  logic [31:0] commit_data;
  logic [3:0]  commit_rob_id;

  register_file dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_val_j(dec_val_j), .dec_val_k(dec_val_k),
    .dec_has_dep_j(dec_has_dep_j), .dec_has_dep_k(dec_has_dep_k),
    .dec_dep_j(dec_dep_j), .dec_dep_k(dec_dep_k),
    .dec_rename_en(dec_rename_en), .dec_rename_reg(dec_rename_reg),
    .dec_rename_rob_id(dec_rename_rob_id),
    .rob_id_j(rob_id_j), .rob_id_k(rob_id_k),
    .rob_ready_j(rob_ready_j), .rob_ready_k(rob_ready_k),
    .rob_data_j(rob_data_j), .rob_data_k(rob_data_k),
    .commit_reg_id(commit_reg_id), .commit_data(commit_data), .commit_rob_id(commit_rob_id)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset;
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
    end
  endtask

  // Architectural effect of one clock edge, applied from the inputs sampled at that edge.
  task automatic model_update;
    int c, r;
    logic old_busy;
    logic [3:0] old_tag;
    if (!rdy_in) return;
    if (flush) begin
      for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_tag[i] = 0; end
      return;
    end
    c = int'(commit_reg_id);
    r = int'(dec_rename_reg);
    old_busy = m_busy[c];
    old_tag  = m_tag[c];
    if (c != 0) begin
      m_val[c] = commit_data;
      if (old_busy && old_tag == commit_rob_id) m_busy[c] = 0;
    end
    if (dec_rename_en && r != 0) begin
      m_busy[r] = 1;
      m_tag[r]  = dec_rename_rob_id;
    end
  endtask

  // Returns {has_dep, dep, val} expected for one read port.
  function automatic logic [36:0] exp_port(input int rs, input logic rdy, input logic [31:0] d);
    if (rs == 0)                                               return {1'b0, 4'd0, 32'd0};
    if (m_busy[rs] && m_tag[rs] == commit_rob_id && int'(commit_reg_id) == rs)
                                                               return {1'b0, 4'd0, commit_data};
    if (m_busy[rs] && rdy)                                     return {1'b0, 4'd0, d};
    if (m_busy[rs])                                            return {1'b1, m_tag[rs], 32'd0};
    return {1'b0, 4'd0, m_val[rs]};
  endfunction

  task automatic check_ports(input string tag);
    logic [36:0] ej, ek;
    ej = exp_port(int'(dec_rs1), rob_ready_j, rob_data_j);
    ek = exp_port(int'(dec_rs2), rob_ready_k, rob_data_k);
    chk({tag, ".val_j"}, dec_val_j, ej[31:0]);
    chk({tag, ".hasdep_j"}, {31'd0, dec_has_dep_j}, {31'd0, ej[36]});
    chk({tag, ".dep_j"}, {28'd0, dec_dep_j}, {28'd0, ej[35:32]});
    chk({tag, ".robid_j"}, {28'd0, rob_id_j}, {28'd0, m_tag[dec_rs1]});
    chk({tag, ".val_k"}, dec_val_k, ek[31:0]);
    chk({tag, ".hasdep_k"}, {31'd0, dec_has_dep_k}, {31'd0, ek[36]});
    chk({tag, ".dep_k"}, {28'd0, dec_dep_k}, {28'd0, ek[35:32]});
    chk({tag, ".robid_k"}, {28'd0, rob_id_k}, {28'd0, m_tag[dec_rs2]});
  endtask

  task automatic idle;
    rdy_in = 1; flush = 0; dec_rename_en = 0; dec_rename_reg = 0; dec_rename_rob_id = 0;
    commit_reg_id = 0; commit_data = 0; commit_rob_id = 0;
    rob_ready_j = 0; rob_ready_k = 0; rob_data_j = 0; rob_data_k = 0;
  endtask

  task automatic tick;
    @(posedge clk_in);
    model_update();
    @(negedge clk_in);
  endtask

  function automatic logic [4:0] pick_reg();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    dec_rs1 = 5; dec_rs2 = 0;
    rst_in = 0;
    model_reset();
    repeat (2) @(negedge clk_in);
    #1;
    chk("rst.val_j", dec_val_j, 32'd0);
    chk("rst.hasdep_j", {31'd0, dec_has_dep_j}, 32'd0);
    chk("rst.robid_j", {28'd0, rob_id_j}, 32'd0);
    rst_in = 1;
    #1;
    // 1: fresh read after reset
    chk("t1.val_j", dec_val_j, 32'd0);
    chk("t1.val_k", dec_val_k, 32'd0);
    chk("t1.hasdep_k", {31'd0, dec_has_dep_k}, 32'd0);
    // 2: rename x5->3, read sees old state this cycle
    dec_rename_en = 1; dec_rename_reg = 5; dec_rename_rob_id = 3;
    #1 chk("t2.prerename_hasdep", {31'd0, dec_has_dep_j}, 32'd0);
    tick();
    dec_rename_en = 0;
    #1;
    chk("t2.hasdep", {31'd0, dec_has_dep_j}, 32'd1);
    chk("t2.dep", {28'd0, dec_dep_j}, 32'd3);
    chk("t2.robid", {28'd0, rob_id_j}, 32'd3);
    rob_ready_j = 1; rob_data_j = 32'hAA;
    #1;
    chk("t2.fwd_val", dec_val_j, 32'hAA);
    chk("t2.fwd_hasdep", {31'd0, dec_has_dep_j}, 32'd0);
    chk("t2.fwd_dep", {28'd0, dec_dep_j}, 32'd0);
    // 3: commit bypass
    rob_ready_j = 0; commit_reg_id = 5; commit_rob_id = 3; commit_data = 32'h1234;
    #1;
    chk("t3.bypass_val", dec_val_j, 32'h1234);
    chk("t3.bypass_hasdep", {31'd0, dec_has_dep_j}, 32'd0);
    tick();
    commit_reg_id = 0; commit_data = 0;
    #1;
    chk("t3.after_val", dec_val_j, 32'h1234);
    chk("t3.after_hasdep", {31'd0, dec_has_dep_j}, 32'd0);
    // 4: stale commit leaves the newer rename in place
    dec_rename_en = 1; dec_rename_reg = 7; dec_rename_rob_id = 2; tick();
    dec_rename_rob_id = 6; tick();
    dec_rename_en = 0; commit_reg_id = 7; commit_rob_id = 2; commit_data = 32'h55; tick();
    commit_reg_id = 0; dec_rs1 = 7;
    #1;
    chk("t4.hasdep", {31'd0, dec_has_dep_j}, 32'd1);
    chk("t4.dep", {28'd0, dec_dep_j}, 32'd6);
    flush = 1; tick(); flush = 0;
    #1 chk("t4.val_after_flush", dec_val_j, 32'h55);
    // 5: same-cycle commit and rename of x9
    commit_reg_id = 9; commit_rob_id = 1; commit_data = 32'h99;
    dec_rename_en = 1; dec_rename_reg = 9; dec_rename_rob_id = 4; tick();
    idle(); dec_rs1 = 9;
    #1;
    chk("t5.hasdep", {31'd0, dec_has_dep_j}, 32'd1);
    chk("t5.dep", {28'd0, dec_dep_j}, 32'd4);
    flush = 1; tick(); flush = 0;
    #1 chk("t5.val", dec_val_j, 32'h99);
    // 6: flush ignores commit; rdy_in low holds everything
    commit_reg_id = 3; commit_rob_id = 0; commit_data = 32'h33; tick();
    commit_reg_id = 0;
    dec_rename_en = 1; dec_rename_reg = 3; dec_rename_rob_id = 10; tick();
    dec_rename_reg = 4; dec_rename_rob_id = 11; tick();
    dec_rename_en = 0;
    rdy_in = 0; flush = 1; commit_reg_id = 3; commit_rob_id = 10; commit_data = 32'hDEAD; tick();
    commit_reg_id = 0; dec_rs1 = 3; dec_rs2 = 4;
    #1;
    chk("t6.hold_dep_j", {27'd0, dec_has_dep_j, dec_dep_j}, {27'd0, 1'b1, 4'd10});
    chk("t6.hold_dep_k", {27'd0, dec_has_dep_k, dec_dep_k}, {27'd0, 1'b1, 4'd11});
    rdy_in = 1; commit_reg_id = 3; tick();
    idle(); dec_rs1 = 3; dec_rs2 = 4;
    #1;
    chk("t6.flush_hasdep_j", {31'd0, dec_has_dep_j}, 32'd0);
    chk("t6.flush_hasdep_k", {31'd0, dec_has_dep_k}, 32'd0);
    chk("t6.val3", dec_val_j, 32'h33);
    // x0 rename is dropped
    dec_rename_en = 1; dec_rename_reg = 0; dec_rename_rob_id = 5; tick();
    idle(); dec_rs1 = 0;
    #1 check_ports("x0");

    for (int n = 0; n < 600; n++) begin
      rdy_in        = ($urandom_range(0, 9) != 0);
      flush         = ($urandom_range(0, 19) == 0);
      dec_rs1       = pick_reg();
      dec_rs2       = pick_reg();
      dec_rename_en = $urandom_range(0, 1) == 1;
      dec_rename_reg    = pick_reg();
      dec_rename_rob_id = 4'($urandom_range(0, 15));
      rob_ready_j   = $urandom_range(0, 2) == 0;
      rob_ready_k   = $urandom_range(0, 2) == 0;
      rob_data_j    = $urandom;
      rob_data_k    = $urandom;
      commit_data   = $urandom;
      commit_reg_id = ($urandom_range(0, 1) == 0) ? 5'd0 : pick_reg();
      if ($urandom_range(0, 3) == 0) commit_reg_id = dec_rs1;
      commit_rob_id = ($urandom_range(0, 1) == 0) ? m_tag[commit_reg_id] : 4'($urandom_range(0, 15));
      #1 check_ports("rnd");
      if (n == 300) begin
        rst_in = 0;
        model_reset();
        #1 check_ports("midrst");
        rst_in = 1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
